// File: rtl/wbu_scoreboard_if.sv
// ----------------------------------------------------------------------------
// wbu_scoreboard_if
//   Upstream (EXU/LSU -> write-back) completion bus.
//   master : producer of completed instructions (drives payload + i_valid)
//   slave  : write-back stage (drives o_ready)
//   Signals:
//     i_valid      completed instruction present
//     o_ready      write-back can accept
//     i_rd_wen     instruction writes rd
//     i_rd         destination register
//     i_is_load    result comes from memory data
//     i_ld_funct3  load type
//     i_addr_lo    load byte offset within the word
//     i_alu_res    non-load result
//     i_mem_rdata  raw aligned-word memory data
// ----------------------------------------------------------------------------
interface wbu_scoreboard_if #(
   parameter int CPU_WIDTH = 32,
   parameter int REG_ADDRW = 5
);
   logic                 i_valid;
   logic                 o_ready;
   logic                 i_rd_wen;
   logic [REG_ADDRW-1:0] i_rd;
   logic                 i_is_load;
   logic [2:0]           i_ld_funct3;
   logic [1:0]           i_addr_lo;
   logic [CPU_WIDTH-1:0] i_alu_res;
   logic [CPU_WIDTH-1:0] i_mem_rdata;

   modport master (
      output i_valid, i_rd_wen, i_rd, i_is_load, i_ld_funct3, i_addr_lo,
             i_alu_res, i_mem_rdata,
      input  o_ready
   );

   modport slave (
      input  i_valid, i_rd_wen, i_rd, i_is_load, i_ld_funct3, i_addr_lo,
             i_alu_res, i_mem_rdata,
      output o_ready
   );
endinterface

// File: rtl/wbu_scoreboard.sv
// ----------------------------------------------------------------------------
// wbu_scoreboard
//   Write-back stage in front of the register file. Accepts completed
//   instructions, aligns/extends load data, registers the result onto the
//   register-file write port, and keeps a 2-bit pending-write counter per
//   architectural register so decode can stall on RAW hazards.
//
//   Optional feature macro: WBU_INSTRET_EN
//     defined   -> o_instret is a 64-bit retired-instruction counter
//     undefined -> o_instret tied to 0, no counter flops
//
//   Ports:
//     i_clk, i_rst_n          clock, async active-low reset
//     up (slave modport)      completion bus from EXU/LSU
//     i_issue, i_issue_rd     decode issues an instruction writing i_issue_rd
//     o_issue_full            counter of i_issue_rd is saturated
//     i_raddr1/2, o_busy1/2   decode source registers / pending-write flags
//     i_flush                 discard all pending state
//     o_wen/o_waddr/o_wdata   register-file write port
//     o_ld_err                pulse with the write for an illegal load funct3
//     o_instret               retired-instruction count
// ----------------------------------------------------------------------------
module wbu_scoreboard #(
   parameter int CPU_WIDTH = 32,
   parameter int REG_ADDRW = 5,
   parameter int REG_COUNT = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   wbu_scoreboard_if.slave      up,
   input  logic                 i_issue,
   input  logic [REG_ADDRW-1:0] i_issue_rd,
   output logic                 o_issue_full,
   input  logic [REG_ADDRW-1:0] i_raddr1,
   input  logic [REG_ADDRW-1:0] i_raddr2,
   output logic                 o_busy1,
   output logic                 o_busy2,
   input  logic                 i_flush,
   output logic                 o_wen,
   output logic [REG_ADDRW-1:0] o_waddr,
   output logic [CPU_WIDTH-1:0] o_wdata,
   output logic                 o_ld_err,
   output logic [63:0]          o_instret
);

   logic                       w_accept;
   logic [7:0]                 w_byte;
   logic [15:0]                w_half;
   logic [CPU_WIDTH-1:0]       w_result;
   logic                       w_ld_bad;
   logic [REG_COUNT-1:0]       w_inc;
   logic [REG_COUNT-1:0]       w_dec;

   logic                       r_wen;
   logic [REG_ADDRW-1:0]       r_waddr;
   logic [CPU_WIDTH-1:0]       r_wdata;
   logic                       r_ld_err;
   logic [REG_COUNT-1:0][1:0]  r_cnt;

   // The register file absorbs one write every cycle; only flush stalls.
   assign up.o_ready = ~i_flush;
   assign w_accept   = up.i_valid & ~i_flush;

   // ---------------- load alignment / extension ----------------
   assign w_byte = up.i_mem_rdata[{up.i_addr_lo, 3'b000} +: 8];
   assign w_half = up.i_addr_lo[1] ? up.i_mem_rdata[31:16] : up.i_mem_rdata[15:0];

   always_comb begin
      w_result = up.i_alu_res;
      w_ld_bad = 1'b0;
      if (up.i_is_load) begin
         case (up.i_ld_funct3)
            3'b000:  w_result = {{(CPU_WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_result = {{(CPU_WIDTH-16){w_half[15]}}, w_half};
            3'b010:  w_result = up.i_mem_rdata;
            3'b100:  w_result = {{(CPU_WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_result = {{(CPU_WIDTH-16){1'b0}}, w_half};
            default: begin
               // Unknown load type still writes the raw word, flagged.
               w_result = up.i_mem_rdata;
               w_ld_bad = 1'b1;
            end
         endcase
      end
   end

   // ---------------- output register ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wen    <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_ld_err <= 1'b0;
      end else if (w_accept) begin
         r_wen    <= up.i_rd_wen & (up.i_rd != '0);
         r_waddr  <= up.i_rd;
         r_wdata  <= w_result;
         r_ld_err <= up.i_is_load & w_ld_bad;
      end else begin
         r_wen    <= 1'b0;
         r_ld_err <= 1'b0;
      end
   end

   assign o_wen    = r_wen;
   assign o_waddr  = r_waddr;
   assign o_wdata  = r_wdata;
   assign o_ld_err = r_ld_err;

   // ---------------- scoreboard ----------------
   // Commit = the cycle the output register presents a write.
   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int i = 1; i < REG_COUNT; i++) begin
         w_inc[i] = i_issue & (i_issue_rd == REG_ADDRW'(i)) & (r_cnt[i] != 2'd3);
         w_dec[i] = r_wen & (r_waddr == REG_ADDRW'(i));
      end
   end

   // Entry 0 is only ever reset, so it stays 0 and x0 never reads busy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_flush) begin
         r_cnt <= '0;
      end else begin
         for (int i = 1; i < REG_COUNT; i++) begin
            case ({w_inc[i], w_dec[i]})
               2'b10:   r_cnt[i] <= r_cnt[i] + 2'd1;
               2'b01:   if (r_cnt[i] != 2'd0) r_cnt[i] <= r_cnt[i] - 2'd1;
               default: ;
            endcase
         end
      end
   end

   assign o_busy1      = (r_cnt[i_raddr1] != 2'd0);
   assign o_busy2      = (r_cnt[i_raddr2] != 2'd0);
   assign o_issue_full = (r_cnt[i_issue_rd] == 2'd3);

   // ---------------- retired-instruction counter ----------------
`ifdef WBU_INSTRET_EN
   logic [63:0] r_instret;
   // Counts every accept (x0 / no-write included); flush does not clear it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      r_instret <= '0;
      else if (w_accept) r_instret <= r_instret + 64'd1;
   end
   assign o_instret = r_instret;
`else
   assign o_instret = '0;
`endif

endmodule

// File: tb/tb_wbu_scoreboard.sv
module tb_wbu_scoreboard;
   localparam int CW = 32;
   localparam int AW = 5;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_issue;
   logic [AW-1:0] i_issue_rd;
   logic          o_issue_full;
   logic [AW-1:0] i_raddr1, i_raddr2;
   logic          o_busy1, o_busy2;
   logic          i_flush;
   logic          o_wen;
   logic [AW-1:0] o_waddr;
   logic [CW-1:0] o_wdata;
   logic          o_ld_err;
   logic [63:0]   o_instret;

   int n_tests = 0;
   int n_fail  = 0;

   wbu_scoreboard_if #(.CPU_WIDTH(CW), .REG_ADDRW(AW)) u_if ();

   wbu_scoreboard #(.CPU_WIDTH(CW), .REG_ADDRW(AW), .REG_COUNT(32)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .up           (u_if),
      .i_issue      (i_issue),
      .i_issue_rd   (i_issue_rd),
      .o_issue_full (o_issue_full),
      .i_raddr1     (i_raddr1),
      .i_raddr2     (i_raddr2),
      .o_busy1      (o_busy1),
      .o_busy2      (o_busy2),
      .i_flush      (i_flush),
      .o_wen        (o_wen),
      .o_waddr      (o_waddr),
      .o_wdata      (o_wdata),
      .o_ld_err     (o_ld_err),
      .o_instret    (o_instret)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic up_drive(input logic v, input logic wen, input logic [AW-1:0] rd,
                           input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [CW-1:0] alu, input logic [CW-1:0] mem);
      u_if.i_valid     = v;
      u_if.i_rd_wen    = wen;
      u_if.i_rd        = rd;
      u_if.i_is_load   = ld;
      u_if.i_ld_funct3 = f3;
      u_if.i_addr_lo   = lo;
      u_if.i_alu_res   = alu;
      u_if.i_mem_rdata = mem;
   endtask

   task automatic idle();
      u_if.i_valid = 1'b0;
   endtask

   logic [63:0] exp_ir;

   initial begin
      i_rst_n = 1'b0; i_issue = 1'b0; i_issue_rd = '0;
      i_raddr1 = '0; i_raddr2 = '0; i_flush = 1'b0;
      up_drive(1'b0, 1'b0, '0, 1'b0, 3'b0, 2'b0, '0, '0);

      // ---- reset ----
      step(); step();
      chk("rst_wen",     {63'd0, o_wen},    64'd0);
      chk("rst_waddr",   {59'd0, o_waddr},  64'd0);
      chk("rst_wdata",   {32'd0, o_wdata},  64'd0);
      chk("rst_ld_err",  {63'd0, o_ld_err}, 64'd0);
      chk("rst_instret", o_instret,         64'd0);
      i_rst_n = 1'b1;
      #1;
      chk("rst_ready",   {63'd0, u_if.o_ready}, 64'd1);
      step();

      // ---- load alignment: back-to-back accepts ----
      up_drive(1'b1, 1'b1, 5'd5, 1'b1, 3'b000, 2'd3, '0, 32'h80FF_7F01);  // LB
      step();
      chk("lb_wen",   {63'd0, o_wen},    64'd1);
      chk("lb_waddr", {59'd0, o_waddr},  64'd5);
      chk("lb_wdata", {32'd0, o_wdata},  64'hFFFF_FF80);
      chk("lb_lderr", {63'd0, o_ld_err}, 64'd0);
      up_drive(1'b1, 1'b1, 5'd5, 1'b1, 3'b100, 2'd3, '0, 32'h80FF_7F01);  // LBU
      step();
      chk("lbu_wdata", {32'd0, o_wdata}, 64'h0000_0080);
      up_drive(1'b1, 1'b1, 5'd5, 1'b1, 3'b001, 2'd2, '0, 32'h80FF_7F01);  // LH hi
      step();
      chk("lh_wdata", {32'd0, o_wdata}, 64'hFFFF_80FF);
      up_drive(1'b1, 1'b1, 5'd6, 1'b1, 3'b101, 2'd0, '0, 32'h80FF_7F01);  // LHU lo
      step();
      chk("lhu_wdata", {32'd0, o_wdata}, 64'h0000_7F01);
      chk("lhu_waddr", {59'd0, o_waddr}, 64'd6);
      up_drive(1'b1, 1'b1, 5'd6, 1'b1, 3'b010, 2'd1, '0, 32'h80FF_7F01);  // LW
      step();
      chk("lw_wdata", {32'd0, o_wdata}, 64'h80FF_7F01);

      // ---- ALU write to x0 ----
      up_drive(1'b1, 1'b1, 5'd0, 1'b0, 3'b000, 2'd0, 32'h1234, '0);
      step();
      idle();
      i_raddr1 = 5'd0;
      #1;
      chk("x0_wen",   {63'd0, o_wen},   64'd0);
      chk("x0_wdata", {32'd0, o_wdata}, 64'h1234);
      chk("x0_busy",  {63'd0, o_busy1}, 64'd0);
`ifdef WBU_INSTRET_EN
      exp_ir = 64'd6;
`else
      exp_ir = 64'd0;
`endif
      chk("instret_6", o_instret, exp_ir);
      step();
      chk("idle_wen", {63'd0, o_wen}, 64'd0);

      // ---- saturate x7, then drain with three commits ----
      i_issue = 1'b1; i_issue_rd = 5'd7; i_raddr1 = 5'd7;
      #1;
      chk("x7_full0", {63'd0, o_issue_full}, 64'd0);
      step(); step(); step();
      i_issue = 1'b0;
      #1;
      chk("x7_full3", {63'd0, o_issue_full}, 64'd1);
      chk("x7_busy3", {63'd0, o_busy1},      64'd1);
      up_drive(1'b1, 1'b1, 5'd7, 1'b0, 3'b000, 2'd0, 32'h7777, '0);
      step();
      chk("x7_c1_wen",   {63'd0, o_wen},   64'd1);
      chk("x7_c1_waddr", {59'd0, o_waddr}, 64'd7);
      step();
      chk("x7_notfull", {63'd0, o_issue_full}, 64'd0);
      step();
      idle();
      #1;
      chk("x7_busy1left", {63'd0, o_busy1}, 64'd1);
      step();
      chk("x7_busy_clr", {63'd0, o_busy1}, 64'd0);

      // ---- issue and commit to x9 in the same cycle ----
      i_raddr2 = 5'd9;
      i_issue = 1'b1; i_issue_rd = 5'd9;
      step();
      i_issue = 1'b0;
      up_drive(1'b1, 1'b1, 5'd9, 1'b0, 3'b000, 2'd0, 32'h9999, '0);
      step();
      idle();
      i_issue = 1'b1; i_issue_rd = 5'd9;  // coincides with commit of x9
      #1;
      chk("x9_commit_wen", {63'd0, o_wen},   64'd1);
      chk("x9_busy_pre",   {63'd0, o_busy2}, 64'd1);
      step();
      i_issue = 1'b0;
      #1;
      chk("x9_busy_same", {63'd0, o_busy2}, 64'd1);
      step();
      chk("x9_busy_hold", {63'd0, o_busy2}, 64'd1);
      up_drive(1'b1, 1'b1, 5'd9, 1'b0, 3'b000, 2'd0, 32'h9999, '0);
      step();
      idle();
      step();
      chk("x9_busy_clr", {63'd0, o_busy2}, 64'd0);

      // ---- flush drops in-flight write and all pending state ----
      i_issue = 1'b1; i_issue_rd = 5'd3; i_raddr1 = 5'd3;
      step();
      i_issue = 1'b0;
      up_drive(1'b1, 1'b1, 5'd3, 1'b0, 3'b000, 2'd0, 32'h3333, '0);
      step();
      // flush cycle: in-flight x3 write visible, a new valid and issue are offered
      up_drive(1'b1, 1'b1, 5'd12, 1'b0, 3'b000, 2'd0, 32'hCCCC, '0);
      i_flush = 1'b1; i_issue = 1'b1; i_issue_rd = 5'd10; i_raddr2 = 5'd10;
      #1;
      chk("fl_ready",  {63'd0, u_if.o_ready}, 64'd0);
      chk("fl_busy_x3", {63'd0, o_busy1},     64'd1);
      step();
      i_flush = 1'b0; i_issue = 1'b0;
      idle();
      #1;
      chk("fl_wen",     {63'd0, o_wen},   64'd0);
      chk("fl_busy1",   {63'd0, o_busy1}, 64'd0);
      chk("fl_busy2",   {63'd0, o_busy2}, 64'd0);
      chk("fl_ready_back", {63'd0, u_if.o_ready}, 64'd1);

      // ---- illegal load funct3 ----
      up_drive(1'b1, 1'b1, 5'd6, 1'b1, 3'b011, 2'd1, '0, 32'hDEAD_BEEF);
      step();
      idle();
      #1;
      chk("bad_wen",   {63'd0, o_wen},    64'd1);
      chk("bad_wdata", {32'd0, o_wdata},  64'hDEAD_BEEF);
      chk("bad_lderr", {63'd0, o_ld_err}, 64'd1);
      step();
      chk("bad_lderr_pulse", {63'd0, o_ld_err}, 64'd0);
`ifdef WBU_INSTRET_EN
      exp_ir = 64'd13;  // 6 + 3 (x7) + 2 (x9) + 1 (x3) + 1 (bad load)
`else
      exp_ir = 64'd0;
`endif
      chk("instret_13", o_instret, exp_ir);

      // ---- asynchronous reset mid-operation ----
      i_issue = 1'b1; i_issue_rd = 5'd11; i_raddr1 = 5'd11;
      up_drive(1'b1, 1'b1, 5'd11, 1'b0, 3'b000, 2'd0, 32'hBBBB, '0);
      step();
      chk("ar_wen_pre",  {63'd0, o_wen},   64'd1);
      chk("ar_busy_pre", {63'd0, o_busy1}, 64'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("ar_wen",     {63'd0, o_wen},   64'd0);
      chk("ar_wdata",   {32'd0, o_wdata}, 64'd0);
      chk("ar_busy",    {63'd0, o_busy1}, 64'd0);
      chk("ar_instret", o_instret,        64'd0);
      i_issue = 1'b0;
      idle();
      step();
      i_rst_n = 1'b1;
      step();
      chk("ar_wen_after", {63'd0, o_wen}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
